// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel clamped
// shadow widths that are committed only at frame boundaries so pulses never glitch.
module servo_pwm_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned MIN_PULSE = 50000,
  parameter int unsigned MAX_PULSE = 100000,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_clk,
  input  logic              reset_low,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_PULSE);

  // Zero parks the channel low; any other request is forced into the safe servo range.
  function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w);
    if (w == '0)
      return '0;
    else if (w < MIN_W)
      return MIN_W;
    else if (w > MAX_W)
      return MAX_W;
    else
      return w;
  endfunction

  logic [CNT_W-1:0]  cnt_p0;
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [CNT_W-1:0]  active [NUM_CH];
  logic [NUM_CH-1:0] en_lat;
  logic              frame_end;
  logic              wr_valid;

  assign frame_end = (cnt_p0 == LAST_CNT);
  assign wr_valid  = wr_en && (32'(wr_ch) < NUM_CH);

  // Stage p0: free-running frame counter
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low)
      cnt_p0 <= '0;
    else if (frame_end)
      cnt_p0 <= '0;
    else
      cnt_p0 <= cnt_p0 + CNT_W'(1);
  end

  // A write landing in the commit cycle is ordered after the commit, so it waits a frame.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      pending <= '0;
      en_lat  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_end) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (pending[i])
            active[i] <= shadow[i];
        end
        en_lat  <= ch_enable;
        pending <= '0;
      end
      if (wr_valid) begin
        shadow[wr_ch]  <= clamp_width(wr_data);
        pending[wr_ch] <= 1'b1;
      end
    end
  end

  // Stage p1: registered pulse outputs and frame marker
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= en_lat[i] && (cnt_p0 < active[i]);
      frame_start <= (cnt_p0 == '0);
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: per-cycle frame-level reference model, a table of clamp
// vectors measured over whole frames, directed corner sequences and random traffic.
module tb_servo_pwm_bank;

  localparam int NCH = 2;
  localparam int PER = 10;
  localparam int MINP = 2;
  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        reset_low;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_data;
  logic [1:0]  ch_enable;
  logic [1:0]  pwm_out;
  logic        frame_start;
  logic [1:0]  pending;

  servo_pwm_bank #(
    .NUM_CH(NCH), .CNT_W(32), .PERIOD(PER), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .CH_W(2)
  ) dut (
    .clock_clk(clk), .reset_low(reset_low), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .ch_enable(ch_enable), .pwm_out(pwm_out),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: t counts clock edges since reset release; the frame phase is t % PER.
  int          t;
  logic [31:0] m_sh  [NCH];
  logic [31:0] m_act [NCH];
  logic [1:0]  m_pend;
  logic [1:0]  m_en;
  logic [1:0]  e_pwm;
  logic        e_fs;

  typedef struct {
    logic [31:0] data;
    int          exp_w;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [31:0] ref_clamp(input logic [31:0] w);
    if (w == 0) return 0;
    if (w < MINP) return MINP;
    if (w > MAXP) return MAXP;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_clear();
    t = 0;
    m_pend = '0;
    m_en = '0;
    for (int i = 0; i < NCH; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
  endtask

  // One clock: predict this cycle's outputs from frame-level rules, then compare.
  task automatic tick();
    int ph;
    ph = t % PER;
    for (int i = 0; i < NCH; i++)
      e_pwm[i] = m_en[i] && (ph < int'(m_act[i]));
    e_fs = (ph == 0);
    if (ph == PER - 1) begin
      for (int i = 0; i < NCH; i++)
        if (m_pend[i]) m_act[i] = m_sh[i];
      m_en = ch_enable;
      m_pend = '0;
    end
    if (wr_en && (int'(wr_ch) < NCH)) begin
      m_sh[wr_ch] = ref_clamp(wr_data);
      m_pend[wr_ch] = 1'b1;
    end
    t++;
    @(posedge clk);
    @(negedge clk);
    check("cycle", 64'({pwm_out, frame_start, pending}), 64'({e_pwm, e_fs, m_pend}));
  endtask

  task automatic write(input logic [1:0] ch, input logic [31:0] d);
    wr_en = 1'b1;
    wr_ch = ch;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Advance until the counter is at phase p (always fewer than PER cycles).
  task automatic goto_phase(input int p);
    for (int n = 0; n < PER && (t % PER) != p; n++) tick();
  endtask

  // Count high cycles of each channel across one whole frame starting at its first cycle.
  task automatic measure(input int drop_phase, output int hi0, output int hi1);
    goto_phase(0);
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < PER; k++) begin
      if (k == drop_phase) ch_enable[0] = 1'b0;
      tick();
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "bench timeout");
  end

  initial begin
    int h0, h1, fs_cnt, pw_cnt;
    vecs[0] = '{32'd1, 2};
    vecs[1] = '{32'd20, 8};
    vecs[2] = '{32'd0, 0};
    vecs[3] = '{32'd2, 2};
    vecs[4] = '{32'd8, 8};
    vecs[5] = '{32'd9, 8};
    vecs[6] = '{32'd7, 7};
    vecs[7] = '{32'hFFFF_FFFF, 8};

    reset_low = 1'b0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_data = '0;
    ch_enable = 2'b11;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_state", 64'({pwm_out, frame_start, pending}), 64'd0);
    reset_low = 1'b1;

    // Idle after reset: outputs low, frame_start once per frame
    fs_cnt = 0;
    pw_cnt = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      tick();
      fs_cnt += int'(frame_start);
      pw_cnt += int'(pwm_out[0]) + int'(pwm_out[1]);
    end
    check("idle_frame_starts", 64'(fs_cnt), 64'd3);
    check("idle_pwm_low", 64'(pw_cnt), 64'd0);

    // ch0 = 5 written mid-frame; pending until boundary, then 5-clock pulses
    goto_phase(4);
    write(2'd0, 32'd5);
    check("pending_after_write", 64'(pending[0]), 64'd1);
    goto_phase(0);
    check("pending_after_commit", 64'(pending[0]), 64'd0);
    measure(-1, h0, h1);
    check("ch0_width5", 64'(h0), 64'd5);
    measure(-1, h0, h1);
    check("ch0_width5_again", 64'(h0), 64'd5);

    // Write in the commit cycle takes two boundaries
    goto_phase(PER - 1);
    write(2'd0, 32'd3);
    measure(-1, h0, h1);
    check("commit_write_old", 64'(h0), 64'd5);
    measure(-1, h0, h1);
    check("commit_write_new", 64'(h0), 64'd3);

    // Enable dropped mid-pulse: the pulse completes, next frame low
    goto_phase(3);
    write(2'd0, 32'd5);
    measure(-1, h0, h1);
    check("pre_drop_width", 64'(h0), 64'd5);
    measure(2, h0, h1);
    check("drop_full_pulse", 64'(h0), 64'd5);
    measure(-1, h0, h1);
    check("drop_next_low", 64'(h0), 64'd0);

    // Clamp table on ch1, one vector per frame pair
    for (int v = 0; v < 8; v++) begin
      goto_phase(3);
      write(2'd1, vecs[v].data);
      measure(-1, h0, h1);
      check($sformatf("clamp_vec%0d", v), 64'(h1), 64'(vecs[v].exp_w));
    end

    // Random traffic against the reference model
    ch_enable = 2'b11;
    for (int k = 0; k < 400; k++) begin
      wr_en = ($urandom_range(3) == 0);
      wr_ch = 2'($urandom_range(3));
      wr_data = ($urandom_range(4) == 0) ? $urandom : 32'($urandom_range(11));
      if ($urandom_range(29) == 0) ch_enable = 2'($urandom_range(3));
      tick();
    end
    wr_en = 1'b0;

    // Asynchronous reset mid-frame while a pulse is high and a write is pending
    ch_enable = 2'b11;
    goto_phase(3);
    write(2'd1, 32'd8);
    measure(-1, h0, h1);
    check("pre_reset_width", 64'(h1), 64'd8);
    goto_phase(1);
    write(2'd0, 32'd4);
    goto_phase(3);
    check("pre_reset_active", 64'({pwm_out[1], pending[0]}), 64'b11);
    reset_low = 1'b0;
    #1;
    check("async_reset", 64'({pwm_out, frame_start, pending}), 64'd0);
    wr_en = 1'b1;
    wr_ch = 2'd3;
    wr_data = 32'd5;
    repeat (2) @(negedge clk);
    check("reset_hold", 64'({pwm_out, frame_start, pending}), 64'd0);
    model_clear();
    reset_low = 1'b1;
    tick();
    wr_en = 1'b0;
    write(2'd2, 32'd6);
    check("bad_ch_ignored", 64'(pending), 64'd0);
    pw_cnt = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      tick();
      pw_cnt += int'(pwm_out[0]) + int'(pwm_out[1]);
    end
    check("post_reset_low", 64'(pw_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
